// File: rtl/exe_stage.sv
// exe_stage: execute stage of the ARM-subset five-stage pipeline.
//
// Takes the ID/EX register contents and applies operand forwarding to Rn and
// Rm. It builds operand 2 as one of three values: a rotated immediate, a
// shifted Rm, or a 12-bit memory offset. It then runs the ALU and computes the
// branch target. The block owns the NZCV status register and the EXE/MEM
// pipeline register.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   freeze                    holds EXE/MEM and status (memory stall)
//   WB_en_in .. s_in          control bits from ID/EX
//   EXE_cmd_in                ALU opcode
//   pc_in                     PC+4 of the instruction
//   Val_Rn_in, Val_Rm_in      register-file operands
//   imm_in, shift_operand_in  operand-2 selection and field
//   signed_imm_in             branch offset in words
//   dest_in                   destination register
//   sel_src1, sel_src2        forwarding selects (01 MEM, 10 WB, else ID)
//   mem_fwd_val, wb_fwd_val   forwarded values
//   branch_taken, branch_addr combinational branch outputs
//   status_out                registered {N,Z,C,V}
//   *_out                     registered EXE/MEM contents
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        WB_en_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        branch_in,
  input  logic        s_in,
  input  logic [3:0]  EXE_cmd_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] Val_Rn_in,
  input  logic [31:0] Val_Rm_in,
  input  logic        imm_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm_in,
  input  logic [3:0]  dest_in,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] mem_fwd_val,
  input  logic [31:0] wb_fwd_val,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [3:0]  status_out,
  output logic        WB_en_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] store_val_out,
  output logic [3:0]  dest_out
);

  // Rotate right; a zero amount yields x because x << 32 is 0.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  logic [31:0] op1;
  logic [31:0] rm_fwd;
  logic [31:0] val2;
  logic [31:0] res;
  logic [32:0] sum;
  logic        c_new;
  logic        v_new;
  logic [3:0]  status_d;
  logic [3:0]  status_q;
  logic        wb_en_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] alu_res_q;
  logic [31:0] store_val_q;
  logic [3:0]  dest_q;

  // Forwarding mux for Rn.
  always_comb begin
    op1 = Val_Rn_in;
    case (sel_src1)
      2'b01:   op1 = mem_fwd_val;
      2'b10:   op1 = wb_fwd_val;
      default: op1 = Val_Rn_in;
    endcase
  end

  // Forwarding mux for Rm.
  always_comb begin
    rm_fwd = Val_Rm_in;
    case (sel_src2)
      2'b01:   rm_fwd = mem_fwd_val;
      2'b10:   rm_fwd = wb_fwd_val;
      default: rm_fwd = Val_Rm_in;
    endcase
  end

  // Operand-2 generator: memory offset, rotated immediate, or shifted Rm.
  always_comb begin
    val2 = rm_fwd;
    if (mem_read_in || mem_write_in) begin
      val2 = {20'd0, shift_operand_in};
    end else if (imm_in) begin
      val2 = ror32({24'd0, shift_operand_in[7:0]}, {shift_operand_in[11:8], 1'b0});
    end else begin
      case (shift_operand_in[6:5])
        2'b00:   val2 = rm_fwd << shift_operand_in[11:7];
        2'b01:   val2 = rm_fwd >> shift_operand_in[11:7];
        2'b10:   val2 = $signed(rm_fwd) >>> shift_operand_in[11:7];
        default: val2 = ror32(rm_fwd, shift_operand_in[11:7]);
      endcase
    end
  end

  // ALU. Subtraction is op1 + ~val2 + carry-in, so bit 32 is directly NOT borrow.
  // Unknown opcodes produce 0, which gives N=0, Z=1 without special casing.
  always_comb begin
    sum   = 33'd0;
    res   = 32'd0;
    c_new = status_q[1];
    v_new = status_q[0];
    case (EXE_cmd_in)
      4'b0001: res = val2;
      4'b1001: res = ~val2;
      4'b0010, 4'b0011: begin
        sum   = {1'b0, op1} + {1'b0, val2}
              + {32'd0, (EXE_cmd_in[0] ? status_q[1] : 1'b0)};
        res   = sum[31:0];
        c_new = sum[32];
        v_new = (op1[31] == val2[31]) && (sum[31] != op1[31]);
      end
      4'b0100, 4'b0101: begin
        sum   = {1'b0, op1} + {1'b0, ~val2}
              + {32'd0, (EXE_cmd_in[0] ? status_q[1] : 1'b1)};
        res   = sum[31:0];
        c_new = sum[32];
        v_new = (op1[31] != val2[31]) && (sum[31] != op1[31]);
      end
      4'b0110: res = op1 & val2;
      4'b0111: res = op1 | val2;
      4'b1000: res = op1 ^ val2;
      default: res = 32'd0;
    endcase
  end

  // Next status value: load new flags only on an unfrozen S-instruction.
  always_comb begin
    status_d = status_q;
    if (s_in && !freeze) begin
      status_d = {res[31], (res == 32'd0), c_new, v_new};
    end else begin
      status_d = status_q;
    end
  end

  // Status register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= 4'd0;
    end else begin
      status_q <= status_d;
    end
  end

  // EXE/MEM pipeline register, held while frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_res_q   <= 32'd0;
      store_val_q <= 32'd0;
      dest_q      <= 4'd0;
    end else if (!freeze) begin
      wb_en_q     <= WB_en_in;
      mem_read_q  <= mem_read_in;
      mem_write_q <= mem_write_in;
      alu_res_q   <= res;
      store_val_q <= rm_fwd;
      dest_q      <= dest_in;
    end
  end

  assign branch_taken  = branch_in;
  assign branch_addr   = pc_in + {{6{signed_imm_in[23]}}, signed_imm_in, 2'b00};
  assign status_out    = status_q;
  assign WB_en_out     = wb_en_q;
  assign mem_read_out  = mem_read_q;
  assign mem_write_out = mem_write_q;
  assign alu_res_out   = alu_res_q;
  assign store_val_out = store_val_q;
  assign dest_out      = dest_q;

endmodule
